// File: rtl/top_pkg.sv
// Shared definitions for the UART loader shell: RX state encoding,
// default timing parameters and the 7-segment hex font.
package top_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_SCAN_DIV     = 50000;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Segment order is {dp,g,f,e,d,c,b,a}, active high, dp always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = 8'h3F;
            4'h1:    seg = 8'h06;
            4'h2:    seg = 8'h5B;
            4'h3:    seg = 8'h4F;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'h6D;
            4'h6:    seg = 8'h7D;
            4'h7:    seg = 8'h07;
            4'h8:    seg = 8'h7F;
            4'h9:    seg = 8'h6F;
            4'hA:    seg = 8'h77;
            4'hB:    seg = 8'h7C;
            4'hC:    seg = 8'h39;
            4'hD:    seg = 8'h5E;
            4'hE:    seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchronizer. valid/frame_err are
// single-cycle pulses on the stop-bit sample; data holds the shifted byte.
module uart_rx
    import top_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          stop_tick;

    // The edge-detect cycle counts toward the half-bit wait, so START begins at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= CW'(1);
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign stop_tick = (state == RX_STOP) && (cnt == FULL_M1);
    assign valid     = stop_tick && rx_sync;
    assign frame_err = stop_tick && !rx_sync;
    assign data      = shift;
    assign busy      = (state != RX_IDLE);

endmodule

// File: rtl/uart_cpu_top.sv
// FPGA I/O shell: assembles little-endian instruction words from UART,
// drives status LEDs and two multiplexed 4-digit 7-segment displays.
module uart_cpu_top
    import top_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SCAN_DIV     = DEFAULT_SCAN_DIV
) (
    input  logic        fpga_clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [7:0]  switches1,
    input  logic [7:0]  switches2,
    input  logic        Button_Mid,
    input  logic        Button_Up,
    output logic [7:0]  led1_out,
    output logic [7:0]  led2_out,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [3:0]  sel1,
    output logic [3:0]  sel2,
    output logic [32:0] UartData,
    output logic        UartOver
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [SW-1:0] SCAN_M1 = SW'(SCAN_DIV - 1);

    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_frame_err;
    logic            rx_busy;

    logic [1:0]      btn_meta, btn_sync, btn_prev;
    logic [7:0]      sw1_meta, sw1_sync, sw2_meta, sw2_sync;
    logic            up_press, mid_press;

    logic [2:0][7:0] lanes;
    logic [31:0]     word;
    logic            strobe;
    logic            over;
    logic [7:0]      count;
    logic [1:0]      byte_idx;
    logic            page;
    logic            err_sticky;

    logic [SW-1:0]   scan_cnt;
    logic [1:0]      digit;
    logic [7:0]      next_seg1, next_seg2;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (fpga_clk),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err),
        .busy      (rx_busy)
    );

    assign up_press  = btn_sync[1] & ~btn_prev[1];
    assign mid_press = btn_sync[0] & ~btn_prev[0];

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            btn_prev   <= '0;
            sw1_meta   <= '0;
            sw1_sync   <= '0;
            sw2_meta   <= '0;
            sw2_sync   <= '0;
            lanes      <= '0;
            word       <= '0;
            strobe     <= 1'b0;
            over       <= 1'b0;
            count      <= '0;
            byte_idx   <= '0;
            page       <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            btn_meta <= {Button_Up, Button_Mid};
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            sw1_meta <= switches1;
            sw1_sync <= sw1_meta;
            sw2_meta <= switches2;
            sw2_sync <= sw2_meta;
            strobe   <= 1'b0;
            // Uses the old value of over, so a same-cycle Button_Up still publishes the word.
            if (rx_valid && !over) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    word   <= {rx_data, lanes[2], lanes[1], lanes[0]};
                    strobe <= 1'b1;
                    if (count != 8'hFF) begin
                        count <= count + 8'd1;
                    end
                end else begin
                    lanes[byte_idx] <= rx_data;
                end
            end
            if (rx_frame_err) begin
                err_sticky <= 1'b1;
            end
            if (up_press) begin
                over <= 1'b1;
            end
            if (mid_press) begin
                page <= ~page;
            end
        end
    end

    always_comb begin
        next_seg1 = hex_to_seg(word[{digit, 2'b00} +: 4]);
        next_seg2 = hex_to_seg(word[{1'b1, digit, 2'b00} +: 4]);
        if (page) begin
            if (digit[1]) begin
                next_seg1 = 8'h00;
                next_seg2 = 8'h00;
            end else begin
                next_seg1 = hex_to_seg(sw1_sync[{digit[0], 2'b00} +: 4]);
                next_seg2 = hex_to_seg(sw2_sync[{digit[0], 2'b00} +: 4]);
            end
        end
    end

    // Segments and selects are registered from the same digit index so they switch together.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= '0;
            sel1     <= 4'b0001;
            sel2     <= 4'b0001;
            seg1     <= 8'h3F;
            seg2     <= 8'h3F;
        end else begin
            if (scan_cnt == SCAN_M1) begin
                scan_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            sel1 <= 4'b0001 << digit;
            sel2 <= 4'b0001 << digit;
            seg1 <= next_seg1;
            seg2 <= next_seg2;
        end
    end

    assign UartData = {strobe, word};
    assign UartOver = over;
    assign led1_out = count;
    assign led2_out = {over, page, rx_busy, err_sticky, 2'b00, byte_idx};

endmodule

// File: tb/tb_uart_cpu_top.sv
// Directed bench for uart_cpu_top: word assembly, framing errors, glitch
// rejection, load-end lockout, display pages and mid-frame reset.
module tb_uart_cpu_top;

    localparam int CPB  = 4;
    localparam int SCAN = 4;

    logic        fpga_clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [7:0]  switches1, switches2;
    logic        Button_Mid, Button_Up;
    logic [7:0]  led1_out, led2_out;
    logic [7:0]  seg1, seg2;
    logic [3:0]  sel1, sel2;
    logic [32:0] UartData;
    logic        UartOver;

    int errors = 0;
    int checks = 0;
    int strobe_count = 0;

    uart_cpu_top #(.CLKS_PER_BIT(CPB), .SCAN_DIV(SCAN)) dut (
        .fpga_clk   (fpga_clk),
        .reset      (reset),
        .rx         (rx),
        .switches1  (switches1),
        .switches2  (switches2),
        .Button_Mid (Button_Mid),
        .Button_Up  (Button_Up),
        .led1_out   (led1_out),
        .led2_out   (led2_out),
        .seg1       (seg1),
        .seg2       (seg2),
        .sel1       (sel1),
        .sel2       (sel2),
        .UartData   (UartData),
        .UartOver   (UartOver)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Every cycle the strobe is high counts, so a stretched strobe shows up as extra counts.
    always @(negedge fpga_clk) begin
        if (reset) strobe_count = 0;
        else if (UartData[32]) strobe_count = strobe_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge fpga_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge fpga_clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge fpga_clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge fpga_clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        applyStimulus(w[7:0], 1'b1);
        applyStimulus(w[15:8], 1'b1);
        applyStimulus(w[23:16], 1'b1);
        applyStimulus(w[31:24], 1'b1);
    endtask

    task automatic press(input int which);
        if (which == 0) Button_Mid = 1'b1; else Button_Up = 1'b1;
        @(negedge fpga_clk);
        Button_Mid = 1'b0;
        Button_Up  = 1'b0;
        repeat (5) @(negedge fpga_clk);
    endtask

    task automatic check_digit(input string tag, input int d, input logic [7:0] e1, input logic [7:0] e2);
        logic [3:0] want;
        want = 4'b0001 << d;
        for (int i = 0; i < 32; i++) begin
            if (sel1 == want) break;
            @(negedge fpga_clk);
        end
        checkOutput({tag, "_sel1"}, sel1, want);
        checkOutput({tag, "_sel2"}, sel2, want);
        checkOutput({tag, "_seg1"}, seg1, e1);
        checkOutput({tag, "_seg2"}, seg2, e2);
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_data"}, UartData, 33'h0);
        checkOutput({tag, "_over"}, UartOver, 1'b0);
        checkOutput({tag, "_led1"}, led1_out, 8'h00);
        checkOutput({tag, "_led2"}, led2_out, 8'h00);
        checkOutput({tag, "_sel1"}, sel1, 4'b0001);
        checkOutput({tag, "_sel2"}, sel2, 4'b0001);
        checkOutput({tag, "_seg1"}, seg1, 8'h3F);
        checkOutput({tag, "_seg2"}, seg2, 8'h3F);
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        switches1 = 8'h00;
        switches2 = 8'h00;
        Button_Mid = 1'b0;
        Button_Up = 1'b0;
        repeat (3) @(negedge fpga_clk);
        check_reset_state("rst");
        reset = 1'b0;
        repeat (4) @(negedge fpga_clk);

        send_word(32'h0010_0093);
        checkOutput("w1_strobes", strobe_count, 1);
        checkOutput("w1_data", UartData, 33'h0_0010_0093);
        checkOutput("w1_led1", led1_out, 8'd1);
        check_digit("w1_d0", 0, 8'h4F, 8'h3F);
        check_digit("w1_d1", 1, 8'h6F, 8'h06);
        check_digit("w1_d2", 2, 8'h3F, 8'h3F);

        send_word(32'h0000_0013);
        checkOutput("w2_strobes", strobe_count, 2);
        checkOutput("w2_data", UartData, 33'h0_0000_0013);
        checkOutput("w2_led1", led1_out, 8'd2);
        checkOutput("w2_idx", led2_out[1:0], 2'd0);

        applyStimulus(8'h55, 1'b0);
        checkOutput("ferr_flag", led2_out[4], 1'b1);
        checkOutput("ferr_idx", led2_out[1:0], 2'd0);
        send_word(32'hDEAD_BEEF);
        checkOutput("w3_strobes", strobe_count, 3);
        checkOutput("w3_data", UartData, 33'h0_DEAD_BEEF);
        checkOutput("w3_led1", led1_out, 8'd3);

        rx = 1'b0;
        @(negedge fpga_clk);
        rx = 1'b1;
        repeat (20) @(negedge fpga_clk);
        checkOutput("glitch_busy", led2_out[5], 1'b0);
        checkOutput("glitch_idx", led2_out[1:0], 2'd0);

        press(1);
        checkOutput("over_level", UartOver, 1'b1);
        checkOutput("over_led", led2_out[7], 1'b1);
        send_word(32'h4433_2211);
        checkOutput("locked_strobes", strobe_count, 3);
        checkOutput("locked_led1", led1_out, 8'd3);
        checkOutput("locked_data", UartData, 33'h0_DEAD_BEEF);
        checkOutput("locked_idx", led2_out[1:0], 2'd0);

        switches1 = 8'hA5;
        switches2 = 8'h3C;
        press(0);
        checkOutput("page_led2", led2_out, 8'hD0);
        check_digit("p1_d0", 0, 8'h6D, 8'h39);
        check_digit("p1_d1", 1, 8'h77, 8'h4F);
        check_digit("p1_d2", 2, 8'h00, 8'h00);
        check_digit("p1_d3", 3, 8'h00, 8'h00);

        rx = 1'b0;
        repeat (10) @(negedge fpga_clk);
        checkOutput("midframe_busy", led2_out[5], 1'b1);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge fpga_clk);
        check_reset_state("rst2");
        reset = 1'b0;
        repeat (4) @(negedge fpga_clk);
        send_word(32'h1234_5678);
        checkOutput("w4_strobes", strobe_count, 1);
        checkOutput("w4_data", UartData, 33'h0_1234_5678);
        checkOutput("w4_led1", led1_out, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
